// File: rtl/axil_master.sv
// AXI4-Lite initiator: converts single-beat valid/ready commands into AXI4-Lite
// read/write transactions and returns data, response code and latency.
module axil_master #(
    parameter int ADDRESS_WIDTH = 18,
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]   cmd_address,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [DATA_WIDTH/8-1:0]    cmd_strobe,

    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_write,
    output logic [DATA_WIDTH-1:0]      resp_data,
    output logic [1:0]                 resp_code,
    output logic [LATENCY_WIDTH-1:0]   resp_latency,

    output logic [31:0]                AXIL_awaddr,
    output logic [2:0]                 AXIL_awprot,
    output logic                       AXIL_awvalid,
    input  logic                       AXIL_awready,
    output logic [DATA_WIDTH-1:0]      AXIL_wdata,
    output logic [DATA_WIDTH/8-1:0]    AXIL_wstrb,
    output logic                       AXIL_wvalid,
    input  logic                       AXIL_wready,
    input  logic [1:0]                 AXIL_bresp,
    input  logic                       AXIL_bvalid,
    output logic                       AXIL_bready,
    output logic [31:0]                AXIL_araddr,
    output logic [2:0]                 AXIL_arprot,
    output logic                       AXIL_arvalid,
    input  logic                       AXIL_arready,
    input  logic [DATA_WIDTH-1:0]      AXIL_rdata,
    input  logic [1:0]                 AXIL_rresp,
    input  logic                       AXIL_rvalid,
    output logic                       AXIL_rready
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WRITE      = 3'd1;
    localparam logic [2:0] ST_WRITE_RESP = 3'd2;
    localparam logic [2:0] ST_READ_ADDR  = 3'd3;
    localparam logic [2:0] ST_READ_DATA  = 3'd4;
    localparam logic [2:0] ST_RESPOND    = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [31:0]              addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]  wstrb_q, wstrb_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic                     bready_q, bready_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic [LATENCY_WIDTH-1:0] latency_q, latency_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_write_q, resp_write_d;
    logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
    logic [1:0]               resp_code_q, resp_code_d;
    logic [LATENCY_WIDTH-1:0] resp_latency_q, resp_latency_d;

    logic [31:0]              cmd_addr_ext;
    logic [LATENCY_WIDTH-1:0] latency_inc;
    logic                     aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                     aw_complete, w_complete;

    assign cmd_addr_ext = 32'(cmd_address) & 32'hFFFF_FFFC;
    assign latency_inc  = (latency_q == '1) ? latency_q : latency_q + LATENCY_WIDTH'(1);

    assign aw_hs = awvalid_q && AXIL_awready;
    assign w_hs  = wvalid_q && AXIL_wready;
    assign b_hs  = bready_q && AXIL_bvalid;
    assign ar_hs = arvalid_q && AXIL_arready;
    assign r_hs  = rready_q && AXIL_rvalid;

    assign aw_complete = aw_done_q || aw_hs;
    assign w_complete  = w_done_q || w_hs;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        bready_d       = bready_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        latency_d      = latency_q;
        resp_valid_d   = resp_valid_q;
        resp_write_d   = resp_write_q;
        resp_data_d    = resp_data_q;
        resp_code_d    = resp_code_q;
        resp_latency_d = resp_latency_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_addr_ext;
                    wdata_d      = cmd_data;
                    wstrb_d      = cmd_strobe;
                    resp_write_d = cmd_write;
                    latency_d    = '0;
                    if (cmd_write) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        // bready is registered, so it is raised for the whole write
                        // phase to be high by the cycle the second of AW/W completes.
                        bready_d  = 1'b1;
                    end else begin
                        state_d   = ST_READ_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                latency_d = latency_inc;
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Any B seen here predates the write data and is not captured.
                if (aw_complete && w_complete) begin
                    state_d = ST_WRITE_RESP;
                end
            end
            ST_WRITE_RESP: begin
                latency_d = latency_inc;
                if (b_hs) begin
                    bready_d       = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_write_d   = 1'b1;
                    resp_data_d    = '0;
                    resp_code_d    = AXIL_bresp;
                    resp_latency_d = latency_inc;
                    state_d        = ST_RESPOND;
                end
            end
            ST_READ_ADDR: begin
                latency_d = latency_inc;
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_READ_DATA;
                end
            end
            ST_READ_DATA: begin
                latency_d = latency_inc;
                if (r_hs) begin
                    rready_d       = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_write_d   = 1'b0;
                    resp_data_d    = AXIL_rdata;
                    resp_code_d    = AXIL_rresp;
                    resp_latency_d = latency_inc;
                    state_d        = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            latency_q      <= '0;
            resp_valid_q   <= 1'b0;
            resp_write_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_code_q    <= '0;
            resp_latency_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            bready_q       <= bready_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            latency_q      <= latency_d;
            resp_valid_q   <= resp_valid_d;
            resp_write_q   <= resp_write_d;
            resp_data_q    <= resp_data_d;
            resp_code_q    <= resp_code_d;
            resp_latency_q <= resp_latency_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);

    assign resp_valid   = resp_valid_q;
    assign resp_write   = resp_write_q;
    assign resp_data    = resp_data_q;
    assign resp_code    = resp_code_q;
    assign resp_latency = resp_latency_q;

    assign AXIL_awaddr  = addr_q;
    assign AXIL_awprot  = 3'b000;
    assign AXIL_awvalid = awvalid_q;
    assign AXIL_wdata   = wdata_q;
    assign AXIL_wstrb   = wstrb_q;
    assign AXIL_wvalid  = wvalid_q;
    assign AXIL_bready  = bready_q;
    assign AXIL_araddr  = addr_q;
    assign AXIL_arprot  = 3'b000;
    assign AXIL_arvalid = arvalid_q;
    assign AXIL_rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master against a delay-configurable AXI4-Lite responder model.
module tb_axil_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [17:0] cmd_address = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_strobe = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_write;
    logic [31:0] resp_data;
    logic [1:0]  resp_code;
    logic [15:0] resp_latency;

    logic [31:0] AXIL_awaddr, AXIL_araddr, AXIL_wdata;
    logic [2:0]  AXIL_awprot, AXIL_arprot;
    logic        AXIL_awvalid, AXIL_wvalid, AXIL_arvalid, AXIL_bready, AXIL_rready;
    logic [3:0]  AXIL_wstrb;
    logic        AXIL_awready = 1'b0, AXIL_wready = 1'b0, AXIL_arready = 1'b0;
    logic        AXIL_bvalid = 1'b0, AXIL_rvalid = 1'b0;
    logic [1:0]  AXIL_bresp = '0, AXIL_rresp = '0;
    logic [31:0] AXIL_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // responder configuration (written by the stimulus only)
    int         cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0;
    int         cfg_ar_delay = 0, cfg_r_delay = 0;
    logic [1:0] cfg_bresp = 2'd0, cfg_rresp = 2'd0;

    // responder state (written by the responder only)
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_seen, w_seen, ar_seen;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] lat_awaddr, lat_wdata, lat_araddr, word;
    logic [3:0]  lat_wstrb;
    logic [31:0] mem [16];
    int          aw_beats, w_beats, b_beats, ar_beats, r_beats, rready_cycles;

    // sampled results of the last response
    logic        r_write;
    logic [31:0] r_data;
    logic [1:0]  r_code;
    logic [15:0] r_lat;

    axil_master dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_data(resp_data), .resp_code(resp_code), .resp_latency(resp_latency),
        .AXIL_awaddr(AXIL_awaddr), .AXIL_awprot(AXIL_awprot), .AXIL_awvalid(AXIL_awvalid),
        .AXIL_awready(AXIL_awready), .AXIL_wdata(AXIL_wdata), .AXIL_wstrb(AXIL_wstrb),
        .AXIL_wvalid(AXIL_wvalid), .AXIL_wready(AXIL_wready), .AXIL_bresp(AXIL_bresp),
        .AXIL_bvalid(AXIL_bvalid), .AXIL_bready(AXIL_bready), .AXIL_araddr(AXIL_araddr),
        .AXIL_arprot(AXIL_arprot), .AXIL_arvalid(AXIL_arvalid), .AXIL_arready(AXIL_arready),
        .AXIL_rdata(AXIL_rdata), .AXIL_rresp(AXIL_rresp), .AXIL_rvalid(AXIL_rvalid),
        .AXIL_rready(AXIL_rready)
    );

    always #5 clock = ~clock;

    // Responder: drives on the falling edge; handshakes flagged here complete at the next rising edge.
    always @(negedge clock) begin
        if (reset) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            AXIL_awready = 0; AXIL_wready = 0; AXIL_arready = 0;
            AXIL_bvalid = 0; AXIL_rvalid = 0;
            for (int i = 0; i < 16; i++) mem[i] = '0;
        end else begin
            if (aw_hs) begin aw_seen = 1; aw_beats++; end
            if (w_hs)  begin w_seen = 1; w_beats++; end
            if (ar_hs) begin ar_seen = 1; ar_beats++; end
            if (b_hs) begin
                b_beats++;
                word = mem[lat_awaddr[5:2]];
                for (int i = 0; i < 4; i++)
                    if (lat_wstrb[i]) word[8*i +: 8] = lat_wdata[8*i +: 8];
                mem[lat_awaddr[5:2]] = word;
                aw_seen = 0; w_seen = 0; AXIL_bvalid = 0; b_cnt = 0;
            end
            if (r_hs) begin r_beats++; ar_seen = 0; AXIL_rvalid = 0; r_cnt = 0; end
            if (AXIL_rready) rready_cycles++;

            AXIL_awready = 0;
            if (AXIL_awvalid && !aw_seen) begin
                if (aw_cnt == cfg_aw_delay) begin AXIL_awready = 1; lat_awaddr = AXIL_awaddr; end
                aw_cnt++;
            end else aw_cnt = 0;

            AXIL_wready = 0;
            if (AXIL_wvalid && !w_seen) begin
                if (w_cnt == cfg_w_delay) begin
                    AXIL_wready = 1; lat_wdata = AXIL_wdata; lat_wstrb = AXIL_wstrb;
                end
                w_cnt++;
            end else w_cnt = 0;

            if (aw_seen && w_seen && !AXIL_bvalid) begin
                if (b_cnt == cfg_b_delay) begin AXIL_bvalid = 1; AXIL_bresp = cfg_bresp; end
                else b_cnt++;
            end

            AXIL_arready = 0;
            if (AXIL_arvalid && !ar_seen) begin
                if (ar_cnt == cfg_ar_delay) begin AXIL_arready = 1; lat_araddr = AXIL_araddr; end
                ar_cnt++;
            end else ar_cnt = 0;

            if (ar_seen && !AXIL_rvalid) begin
                if (r_cnt == cfg_r_delay) begin
                    AXIL_rvalid = 1; AXIL_rdata = mem[lat_araddr[5:2]]; AXIL_rresp = cfg_rresp;
                end else r_cnt++;
            end

            aw_hs = AXIL_awvalid && AXIL_awready;
            w_hs  = AXIL_wvalid && AXIL_wready;
            ar_hs = AXIL_arvalid && AXIL_arready;
            b_hs  = AXIL_bvalid && AXIL_bready;
            r_hs  = AXIL_rvalid && AXIL_rready;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Present a command; returns on the falling edge right after acceptance.
    task automatic issue(input logic w, input logic [17:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clock);
        cmd_valid = 1; cmd_write = w; cmd_address = a; cmd_data = d; cmd_strobe = s;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clock); n++; end
        if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clock);
        cmd_valid = 0;
    endtask

    // Wait for the response, sample it and let it be consumed.
    task automatic collect();
        int n;
        n = 0;
        while (!resp_valid && n < 80000) begin @(negedge clock); n++; end
        if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
        r_write = resp_write; r_data = resp_data; r_code = resp_code; r_lat = resp_latency;
        @(negedge clock);
    endtask

    initial begin
        int aw0, w0, b0, rr0;
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_valids", {27'd0, AXIL_awvalid, AXIL_wvalid, AXIL_arvalid, AXIL_bready, AXIL_rready}, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fields", {resp_latency, 13'd0, resp_write, resp_code}, 32'd0);
        reset = 0;

        // zero-wait write
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        issue(1'b1, 18'h00010, 32'hDEADBEEF, 4'hF);
        check("w1_awvalid_c1", 32'(AXIL_awvalid), 32'd1);
        check("w1_wvalid_c1", 32'(AXIL_wvalid), 32'd1);
        collect();
        check("w1_awaddr", lat_awaddr, 32'h00000010);
        check("w1_beats", 32'((aw_beats - aw0) * 100 + (w_beats - w0) * 10 + (b_beats - b0)), 32'd111);
        check("w1_resp_write", 32'(r_write), 32'd1);
        check("w1_resp_code", 32'(r_code), 32'd0);
        check("w1_resp_data", r_data, 32'd0);
        check("w1_latency", 32'(r_lat), 32'd2);

        // read with R three cycles after the AR handshake
        cfg_r_delay = 2;
        rr0 = rready_cycles;
        issue(1'b0, 18'h00010, 32'h0, 4'h0);
        collect();
        check("r1_araddr", lat_araddr, 32'h00000010);
        check("r1_resp_write", 32'(r_write), 32'd0);
        check("r1_resp_data", r_data, 32'hDEADBEEF);
        check("r1_latency", 32'(r_lat), 32'd4);
        check("r1_rready_cycles", 32'(rready_cycles - rr0), 32'd3);
        cfg_r_delay = 0;

        // W first, AW three cycles later
        cfg_aw_delay = 3;
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        issue(1'b1, 18'h00030, 32'h0BADF00D, 4'h3);
        @(negedge clock);
        check("wfirst_wvalid_dropped", 32'(AXIL_wvalid), 32'd0);
        check("wfirst_awvalid_held", 32'(AXIL_awvalid), 32'd1);
        collect();
        check("wfirst_beats", 32'((aw_beats - aw0) * 100 + (w_beats - w0) * 10 + (b_beats - b0)), 32'd111);
        check("wfirst_latency", 32'(r_lat), 32'd5);
        cfg_aw_delay = 0;

        // AW first, W three cycles later
        cfg_w_delay = 3;
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        issue(1'b1, 18'h00034, 32'hCAFE1234, 4'hF);
        @(negedge clock);
        check("awfirst_awvalid_dropped", 32'(AXIL_awvalid), 32'd0);
        check("awfirst_wvalid_held", 32'(AXIL_wvalid), 32'd1);
        collect();
        check("awfirst_beats", 32'((aw_beats - aw0) * 100 + (w_beats - w0) * 10 + (b_beats - b0)), 32'd111);
        check("awfirst_latency", 32'(r_lat), 32'd5);
        cfg_w_delay = 0;

        // strobed write lands only in the low half-word
        issue(1'b0, 18'h00030, 32'h0, 4'h0);
        collect();
        check("strb_readback", r_data, 32'h0000F00D);

        // misaligned address
        issue(1'b1, 18'h00013, 32'h11223344, 4'hF);
        collect();
        check("mis_awaddr", lat_awaddr, 32'h00000010);
        issue(1'b0, 18'h00013, 32'h0, 4'h0);
        collect();
        check("mis_araddr", lat_araddr, 32'h00000010);
        check("mis_data", r_data, 32'h11223344);

        // response back-pressure with the next command already waiting
        resp_ready = 0;
        issue(1'b1, 18'h00020, 32'h12345678, 4'hF);
        cmd_valid = 1; cmd_write = 0; cmd_address = 18'h00020;
        begin
            int n;
            n = 0;
            while (!resp_valid && n < 100) begin @(negedge clock); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_fields", {resp_latency, 13'd0, resp_write, resp_code}, 32'h0002_0004);
            @(negedge clock);
        end
        resp_ready = 1;
        @(negedge clock);
        check("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
        check("bp_resp_dropped", 32'(resp_valid), 32'd0);
        @(negedge clock);
        cmd_valid = 0;
        check("bp_next_accepted", 32'(cmd_ready), 32'd0);
        collect();
        check("bp_read_data", r_data, 32'h12345678);
        check("bp_read_latency", 32'(r_lat), 32'd2);

        // error response passes through
        cfg_rresp = 2'd2;
        issue(1'b0, 18'h00020, 32'h0, 4'h0);
        collect();
        check("slverr_code", 32'(r_code), 32'd2);
        check("slverr_data", r_data, 32'h12345678);
        cfg_rresp = 2'd0;

        cfg_bresp = 2'd3;
        issue(1'b1, 18'h00024, 32'h5, 4'hF);
        collect();
        check("decerr_code", 32'(r_code), 32'd3);
        cfg_bresp = 2'd0;

        // latency counter saturation
        cfg_b_delay = 70000;
        issue(1'b1, 18'h00028, 32'h77, 4'hF);
        collect();
        check("sat_latency", 32'(r_lat), 32'h0000FFFF);
        cfg_b_delay = 0;

        // reset in the middle of a write
        cfg_aw_delay = 20; cfg_w_delay = 20;
        issue(1'b1, 18'h0002C, 32'h99, 4'hF);
        check("mid_awvalid_before", 32'(AXIL_awvalid), 32'd1);
        reset = 1;
        @(negedge clock);
        check("mid_valids_cleared", {27'd0, AXIL_awvalid, AXIL_wvalid, AXIL_arvalid, AXIL_bready, AXIL_rready}, 32'd0);
        reset = 0;
        cfg_aw_delay = 0; cfg_w_delay = 0;
        @(negedge clock);
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        issue(1'b1, 18'h00008, 32'hA5A5A5A5, 4'hF);
        collect();
        check("post_rst_latency", 32'(r_lat), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- AXI4-Lite initiator. It turns single-beat commands from a simple valid/ready command port into AXI4-Lite read or write transactions.
- It returns the read data or the write completion, the response code and a cycle-accurate latency figure on a valid/ready response port.
- It sits between on-chip logic (test sequencers, host-side models, register agents) and any AXI4-Lite responder, including the CSR DPRAM bridge in the shell.
- It has one outstanding transaction at a time.

Parameters:
- ADDRESS_WIDTH, 18: byte-address width of the command port; zero-extended to 32 bits on the AXI address buses.
- DATA_WIDTH, 32: AXI4-Lite data width; only 32 is supported.
- LATENCY_WIDTH, 16: width of the saturating latency counter.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDRESS_WIDTH  byte address.
- cmd_data  in  DATA_WIDTH  write data.
- cmd_strobe  in  DATA_WIDTH/8  write byte strobes.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_write  out  1  echoes cmd_write of the completed command.
- resp_data  out  DATA_WIDTH  read data; 0 for writes.
- resp_code  out  2  captured BRESP/RRESP.
- resp_latency  out  LATENCY_WIDTH  cycles from acceptance to the B/R handshake.
- AXIL_awaddr, AXIL_awprot, AXIL_awvalid  out  32/3/1.
- AXIL_awready  in  1.
- AXIL_wdata, AXIL_wstrb, AXIL_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1.
- AXIL_wready  in  1.
- AXIL_bresp  in  2.
- AXIL_bvalid  in  1.
- AXIL_bready  out  1.
- AXIL_araddr, AXIL_arprot, AXIL_arvalid  out  32/3/1.
- AXIL_arready  in  1.
- AXIL_rdata  in  DATA_WIDTH.
- AXIL_rresp  in  2.
- AXIL_rvalid  in  1.
- AXIL_rready  out  1.

Behaviour:
- Reset: state goes to IDLE. All of the following are 0: AXIL_*valid, AXIL_bready, AXIL_rready, resp_valid, resp_write, resp_data, resp_code, resp_latency and the latency counter.
- Reset mid-transaction abandons the transaction on the next edge. The responder shares the same reset.
- States and transitions:
  - IDLE -> WRITE when a write is accepted.
  - IDLE -> READ_ADDR when a read is accepted.
  - WRITE -> WRITE_RESP once both the AW and the W handshakes have occurred.
  - WRITE_RESP -> RESPOND on the B handshake.
  - READ_ADDR -> READ_DATA on the AR handshake.
  - READ_DATA -> RESPOND on the R handshake.
  - RESPOND -> IDLE on the resp handshake.
- cmd_ready = (state == IDLE); it is combinational from the state only.
- On acceptance, register the address, data, strobe and write flag. All AXI outputs are driven from registers.
- Address output = {zero-extend cmd_address[ADDRESS_WIDTH-1:2], 2'b00}. The low two bits are always forced to zero. awprot and arprot = 3'b000.
- WRITE state:
  - AXIL_awvalid and AXIL_wvalid assert on the cycle after acceptance.
  - Each valid drops independently on the edge after its own handshake.
  - AW and W may complete in the same cycle or in either order.
  - Payloads stay stable while valid is high.
- WRITE_RESP: AXIL_bready = 1. It is also 1 in the cycle the second of AW/W completes, so a B arriving in the following cycle is taken immediately.
- READ_ADDR: AXIL_arvalid = 1 until arready.
- READ_DATA: AXIL_rready = 1.
- B/R arriving earlier than allowed by AXI ordering is not possible. A B seen before both AW and W have completed is ignored (not captured).
- On the B/R handshake, capture resp_code and resp_data (rdata for reads, 0 for writes) and assert resp_valid on the next edge.
- resp_* outputs hold stable while resp_valid && !resp_ready.
- Latency counter:
  - Cleared to 0 on the acceptance edge.
  - Increments by 1 each cycle in WRITE, WRITE_RESP, READ_ADDR and READ_DATA, including the handshake cycle.
  - Saturates at 2^LATENCY_WIDTH-1; it never wraps.
  - The value is copied to resp_latency with the response.
- Minimum turnaround with a zero-wait responder: write latency 2, read latency 2.
- Back-to-back commands: the next command is accepted on the cycle after the resp handshake (one IDLE cycle).
- resp_code is passed through unmodified. SLVERR (2) and DECERR (3) do not change flow.

Test Plan:
- Write to byte addr 0x00010 with data 0xDEADBEEF, strb 0xF, against a zero-wait responder (aw/w ready = 1, bvalid one cycle later) -> awaddr 0x00000010, a single AW/W beat, resp_write = 1, resp_code = 0, resp_latency = 2.
- Read of the same address from a DPRAM-bridge model (ar then rvalid three cycles later) -> araddr 0x10, resp_data 0xDEADBEEF, resp_latency = 4, rready high only in READ_DATA.
- Write where wready comes 3 cycles before awready, then the reverse order -> each valid drops individually, exactly one B handshake, resp_latency reflects the slower channel + 1.
- Misaligned address 0x00013 -> AXIL_awaddr/AXIL_araddr = 0x00000010.
- resp_ready held low for 5 cycles with cmd_valid high -> cmd_ready stays 0 and resp_* are stable. After the resp handshake the next command is accepted exactly 1 cycle later.
- Responder returns rresp = 2 -> resp_code = 2. The responder stalls bvalid for 70000 cycles -> resp_latency = 0xFFFF (saturated). reset asserted mid-WRITE -> all valids are 0 on the next edge and cmd_ready = 1 after reset deasserts.
